inst_fetcher: RTL and testbench
===============================

// Module: inst_fetcher
// PURPOSE
//  Owns the PC. Presents it to the instruction cache each cycle.
//  On a miss, reads the 4 instruction bytes from byte-wide RAM through the memory arbiter,
//  refills the cache, then re-looks-up.
//  Delivers {inst, pc} to the decoder over a valid/ready handshake.
//  Accepts redirects (flush) from branch resolution.
// PARAMETERS
//  RESET_PC  32'h0  PC loaded on reset; bits [1:0] must be 0
// PORTS
//  clk_in      in   1   clock; all state on posedge
//  rst_in      in   1   synchronous, active-high reset
//  rdy_in      in   1   0 = freeze all state and hold all outputs; ic_we forced 0
//  ic_addr     out  32  lookup/refill address to cache (= pc)
//  ic_hit      in   1   cache hit for ic_addr (combinational)
//  ic_data     in   32  cached instruction, valid when ic_hit
//  ic_we       out  1   write ic_wdata at ic_addr (1-cycle pulse)
//  ic_wdata    out  32  assembled instruction word
//  mem_req     out  1   request RAM ownership from arbiter
//  mem_gnt     in   1   arbiter grant; held while mem_req stays high
//  mem_addr    out  32  byte address; valid while granted
//  mem_din     in   8   read byte; returns 1 cycle after its mem_addr
//  flush       in   1   redirect fetch
//  flush_pc    in   32  redirect target; bits [1:0] ignored (forced 0)
//  inst_valid  out  1   inst/inst_pc valid to decoder
//  inst        out  32  instruction
//  inst_pc     out  32  PC of inst
//  inst_ready  in   1   decoder accepts when inst_valid && inst_ready
// BEHAVIOUR
//  Reset: pc=RESET_PC, state=LOOKUP, inst_valid=0, inst=0, inst_pc=0, mem_req=0, ic_we=0, counters=0.
//  States: LOOKUP, FILL, WRITE.
//  slot_free = !inst_valid || inst_ready.
//  LOOKUP: ic_addr=pc.
//    - ic_hit && slot_free: next cycle inst=ic_data, inst_pc=pc, inst_valid=1, pc+=4.
//    - ic_hit && !slot_free: hold everything.
//    - !ic_hit: go to FILL with mem_req=1 (the miss is handled even if the slot is busy).
//    - Hit latency: inst_valid is registered, 1 cycle after pc is presented; 1 inst/cycle sustained.
//  FILL (T = first cycle with mem_req && mem_gnt):
//    - mem_addr = pc+0, +1, +2, +3 on cycles T..T+3.
//    - Bytes are sampled on T+1..T+4, little-endian: byte k -> word[8k+7:8k].
//    - Issue counter and receive counter are both 3 bits; mem_req falls at T+4.
//    - While mem_gnt=0: wait, issue nothing.
//  WRITE (T+5): ic_we=1, ic_addr=pc, ic_wdata=word. Next state is LOOKUP.
//    - The next cycle hits; inst_valid at T+7 if slot_free.
//  inst_valid && !inst_ready: inst/inst_pc held stable.
//  A consumed word with no new hit drops inst_valid to 0.
//  flush (highest priority, any state):
//    - Next cycle pc=flush_pc&~3, inst_valid=0, state=LOOKUP, mem_req=0, counters=0.
//    - A partial fill is discarded (no ic_we).
//    - flush in the WRITE cycle: the write still completes (line is correct); pc redirects.
//    - flush with hit in the same cycle: the hit is discarded.
//    - flush with an inst handshake in the same cycle: the handshake counts as done.
//  rdy_in=0: no register changes, no counter advance, no bytes sampled.
//    - The arbiter/RAM is paused by the same rdy_in, so the byte timing is preserved.
//  Reset mid-FILL: as reset; mem_req low the next cycle; no ic_we.
//  pc arithmetic: 32-bit wrap (32'hFFFFFFFC + 4 = 0); byte addresses wrap the same way.
// STRUCTURE
//  Shared macros header additions:
//    - `IF_ST_LOOKUP/`IF_ST_FILL/`IF_ST_WRITE (2-bit encodings)
//    - `INST_W 32
//    - `MEM_BYTE_W 8
//  Keep existing ICACHE_* macros there.
//  Optional sub-module byte_word_assembler: 4x8 shift/insert, clear, done flag.
//  Everything else (FSM, pc, output reg) is inline.
// TESTING
//  1 Reset, RESET_PC=0, cache pre-hit, inst_ready=1 -> inst_pc 0,4,8 on consecutive cycles;
//    inst_valid rises 1 cycle after reset release.
//  2 Miss at pc=0x100, mem_gnt=1 immediately, bytes 13,05,00,00
//    -> mem_addr 100..103; ic_we with ic_wdata=32'h00000513 at T+5; inst valid T+7.
//  3 inst_ready=0 for 5 cycles while valid -> inst/inst_pc constant, pc not advanced;
//    release -> next pc delivered next cycle.
//  4 flush_pc=0x203 during FILL after 2 bytes -> mem_req low next cycle, no ic_we,
//    next ic_addr=0x200, inst_valid=0 meanwhile.
//  5 rdy_in low 3 cycles mid-FILL -> counters/mem_addr frozen; assembled word still correct after resume.
//  6 mem_gnt held low 4 cycles after the miss -> mem_req stays 1, no bytes sampled;
//    fill starts on the first grant cycle.

Source files
------------

// File: rtl/inst_fetcher_pkg.sv
// Shared widths, state encoding and helpers for the instruction fetcher.
package inst_fetcher_pkg;

    localparam int INST_W     = 32;
    localparam int MEM_BYTE_W = 8;
    localparam int FILL_CNT_W = 3;

    localparam logic [FILL_CNT_W-1:0] FILL_BYTES = 3'd4;
    localparam logic [FILL_CNT_W-1:0] FILL_LAST  = 3'd3;

    typedef enum logic [1:0] {
        IF_ST_LOOKUP = 2'd0,
        IF_ST_FILL   = 2'd1,
        IF_ST_WRITE  = 2'd2
    } if_state_e;

    function automatic logic [INST_W-1:0] word_align(
        input logic [INST_W-1:0] a
    );
        return a & ~32'd3;
    endfunction

endpackage

// File: rtl/inst_fetcher_asm.sv
// Little-endian byte-to-word assembler used during a cache refill.
module inst_fetcher_asm
    import inst_fetcher_pkg::*;
(
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  clr_i,
    input  logic                  en_i,
    input  logic [MEM_BYTE_W-1:0] byte_i,
    output logic [INST_W-1:0]     word_o,
    output logic [FILL_CNT_W-1:0] cnt_o
);

    logic [INST_W-1:0]     word_q;
    logic [INST_W-1:0]     word_d;
    logic [FILL_CNT_W-1:0] cnt_q;
    logic [FILL_CNT_W-1:0] cnt_d;

    // Shifting in from the top leaves byte 0 in the low lane after four inserts.
    always_comb begin
        word_d = word_q;
        cnt_d  = cnt_q;
        if (clr_i) begin
            cnt_d = '0;
        end else if (en_i) begin
            word_d = {byte_i, word_q[INST_W-1:MEM_BYTE_W]};
            cnt_d  = cnt_q + 3'd1;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            word_q <= '0;
            cnt_q  <= '0;
        end else begin
            word_q <= word_d;
            cnt_q  <= cnt_d;
        end
    end

    assign word_o = word_q;
    assign cnt_o  = cnt_q;

endmodule

// File: rtl/inst_fetcher.sv
// Instruction fetcher: owns the PC, looks up the I-cache, refills on miss
// from byte-wide RAM and hands {inst, pc} to the decoder.
module inst_fetcher
    import inst_fetcher_pkg::*;
#(
    parameter logic [INST_W-1:0] RESET_PC = 32'h0
) (
    input  logic                  clk_in,
    input  logic                  rst_in,
    input  logic                  rdy_in,
    output logic [INST_W-1:0]     ic_addr,
    input  logic                  ic_hit,
    input  logic [INST_W-1:0]     ic_data,
    output logic                  ic_we,
    output logic [INST_W-1:0]     ic_wdata,
    output logic                  mem_req,
    input  logic                  mem_gnt,
    output logic [INST_W-1:0]     mem_addr,
    input  logic [MEM_BYTE_W-1:0] mem_din,
    input  logic                  flush,
    input  logic [INST_W-1:0]     flush_pc,
    output logic                  inst_valid,
    output logic [INST_W-1:0]     inst,
    output logic [INST_W-1:0]     inst_pc,
    input  logic                  inst_ready
);

    if_state_e             state_q, state_d;
    logic [INST_W-1:0]     pc_q, pc_d;
    logic                  valid_q, valid_d;
    logic [INST_W-1:0]     inst_q, inst_d;
    logic [INST_W-1:0]     inst_pc_q, inst_pc_d;
    logic                  mem_req_q, mem_req_d;
    logic [FILL_CNT_W-1:0] issue_q, issue_d;

    logic                  fill_en;
    logic                  fill_clr;
    logic [FILL_CNT_W-1:0] recv_cnt;
    logic [INST_W-1:0]     fill_word;
    logic                  slot_free;

    assign slot_free = !valid_q || inst_ready;

    inst_fetcher_asm u_asm (
        .clk_i  (clk_in),
        .rst_i  (rst_in),
        .clr_i  (fill_clr && rdy_in),
        .en_i   (fill_en && rdy_in),
        .byte_i (mem_din),
        .word_o (fill_word),
        .cnt_o  (recv_cnt)
    );

    always_comb begin
        state_d   = state_q;
        pc_d      = pc_q;
        valid_d   = valid_q;
        inst_d    = inst_q;
        inst_pc_d = inst_pc_q;
        mem_req_d = mem_req_q;
        issue_d   = issue_q;
        fill_en   = 1'b0;
        fill_clr  = 1'b0;

        if (valid_q && inst_ready) begin
            valid_d = 1'b0;
        end

        unique case (state_q)
            IF_ST_LOOKUP: begin
                fill_clr = 1'b1;
                if (ic_hit) begin
                    if (slot_free) begin
                        inst_d    = ic_data;
                        inst_pc_d = pc_q;
                        valid_d   = 1'b1;
                        pc_d      = pc_q + 32'd4;
                    end
                end else begin
                    state_d   = IF_ST_FILL;
                    mem_req_d = 1'b1;
                    issue_d   = '0;
                end
            end
            IF_ST_FILL: begin
                if (mem_req_q && mem_gnt && issue_q < FILL_BYTES) begin
                    issue_d = issue_q + 3'd1;
                    if (issue_q == FILL_LAST) begin
                        mem_req_d = 1'b0;
                    end
                end
                // A byte is due one cycle after each issued address.
                if (recv_cnt < issue_q) begin
                    fill_en = 1'b1;
                    if (recv_cnt == FILL_LAST) begin
                        state_d = IF_ST_WRITE;
                    end
                end
            end
            IF_ST_WRITE: begin
                state_d = IF_ST_LOOKUP;
                issue_d = '0;
            end
            default: begin
                state_d = IF_ST_LOOKUP;
            end
        endcase

        if (flush) begin
            pc_d      = word_align(flush_pc);
            valid_d   = 1'b0;
            state_d   = IF_ST_LOOKUP;
            mem_req_d = 1'b0;
            issue_d   = '0;
            fill_en   = 1'b0;
            fill_clr  = 1'b1;
        end
    end

    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            state_q   <= IF_ST_LOOKUP;
            pc_q      <= RESET_PC;
            valid_q   <= 1'b0;
            inst_q    <= '0;
            inst_pc_q <= '0;
            mem_req_q <= 1'b0;
            issue_q   <= '0;
        end else if (rdy_in) begin
            state_q   <= state_d;
            pc_q      <= pc_d;
            valid_q   <= valid_d;
            inst_q    <= inst_d;
            inst_pc_q <= inst_pc_d;
            mem_req_q <= mem_req_d;
            issue_q   <= issue_d;
        end
    end

    assign ic_addr    = pc_q;
    assign ic_we      = rdy_in && (state_q == IF_ST_WRITE);
    assign ic_wdata   = fill_word;
    assign mem_req    = mem_req_q;
    assign mem_addr   = pc_q + {29'd0, issue_q};
    assign inst_valid = valid_q;
    assign inst       = inst_q;
    assign inst_pc    = inst_pc_q;

endmodule

// File: tb/tb_inst_fetcher.sv
// Bench for inst_fetcher: cache/RAM/arbiter models, stream scoreboard,
// directed scenarios followed by randomized traffic.
module tb_inst_fetcher;

    localparam logic [31:0] RESET_PC = 32'h0;

    logic        clk_in = 1'b0;
    logic        rst_in, rdy_in, ic_hit, ic_we, mem_req, mem_gnt;
    logic        flush, inst_valid, inst_ready;
    logic [31:0] ic_addr, ic_data, ic_wdata, mem_addr, flush_pc;
    logic [31:0] inst, inst_pc;
    logic [7:0]  mem_din = 8'h00;
    logic        gnt_now;
    logic        granted_q = 1'b0;

    int n_tests = 0;
    int n_fail  = 0;
    int n_deliv = 0;

    logic [31:0] redir_q [$];
    logic [31:0] cache [logic [31:0]];
    logic [7:0]  ram_ovr [logic [31:0]];

    always #5 clk_in = ~clk_in;

    inst_fetcher #(.RESET_PC(RESET_PC)) dut (
        .clk_in     (clk_in),
        .rst_in     (rst_in),
        .rdy_in     (rdy_in),
        .ic_addr    (ic_addr),
        .ic_hit     (ic_hit),
        .ic_data    (ic_data),
        .ic_we      (ic_we),
        .ic_wdata   (ic_wdata),
        .mem_req    (mem_req),
        .mem_gnt    (mem_gnt),
        .mem_addr   (mem_addr),
        .mem_din    (mem_din),
        .flush      (flush),
        .flush_pc   (flush_pc),
        .inst_valid (inst_valid),
        .inst       (inst),
        .inst_pc    (inst_pc),
        .inst_ready (inst_ready)
    );

    function automatic logic [7:0] ram_byte(input logic [31:0] a);
        if (ram_ovr.exists(a)) return ram_ovr[a];
        return a[7:0] ^ a[15:8] ^ a[31:24] ^ 8'hA5 ^ {a[1:0], a[7:2]};
    endfunction

    function automatic logic [31:0] ram_word(input logic [31:0] a);
        return {ram_byte(a + 32'd3), ram_byte(a + 32'd2),
                ram_byte(a + 32'd1), ram_byte(a)};
    endfunction

    task automatic check(input string name, input logic [127:0] act,
                         input logic [127:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Cache lookup is combinational in ic_addr, which only moves at posedge.
    always @(negedge clk_in) begin
        ic_hit  = cache.exists(ic_addr);
        ic_data = ic_hit ? cache[ic_addr] : 32'hDEAD_BEEF;
    end

    assign mem_gnt = mem_req && (granted_q || gnt_now);

    always @(posedge clk_in) begin
        if (rdy_in && ic_we) cache[ic_addr] = ic_wdata;
        if (rdy_in) begin
            if (mem_req && mem_gnt) mem_din <= ram_byte(mem_addr);
            granted_q <= mem_req && mem_gnt;
        end
    end

    // Scoreboard: expected stream is sequential PCs, restarted by reset/flush.
    logic [31:0] exp_pc = RESET_PC;
    logic [31:0] prev_inst, prev_pc;
    logic        prev_hold = 1'b0;
    int          fill_k = 0;
    int          idle = 0;

    always @(negedge clk_in) begin
        if (rst_in) begin
            exp_pc    = RESET_PC;
            idle      = 0;
            prev_hold = 1'b0;
        end else begin
            if (prev_hold)
                check("hold_stable", 128'({inst_valid, inst, inst_pc}),
                      128'({1'b1, prev_inst, prev_pc}));
            if (rdy_in && inst_valid && inst_ready) begin
                check("deliver", 128'({inst, inst_pc}),
                      128'({ram_word(exp_pc), exp_pc}));
                exp_pc = exp_pc + 32'd4;
                n_deliv++;
                idle = 0;
            end else begin
                idle++;
                if (idle > 400) begin
                    n_tests++;
                    n_fail++;
                    $display("FAIL progress: no delivery for %0d cycles (limit 400)", idle);
                    idle = 0;
                end
            end
            if (rdy_in && flush) begin
                if (redir_q.size() == 0) begin
                    n_tests++;
                    n_fail++;
                    $display("FAIL redirect_queue: got empty expected a target");
                end else begin
                    exp_pc = redir_q.pop_front();
                end
            end
            prev_hold = inst_valid && !(rdy_in && (inst_ready || flush));
            prev_inst = inst;
            prev_pc   = inst_pc;
        end
        if (!mem_req) begin
            fill_k = 0;
        end else if (rdy_in && mem_gnt) begin
            check("fill_addr", 128'({fill_k < 4, mem_addr}),
                  128'({1'b1, ic_addr + 32'(fill_k)}));
            fill_k++;
        end
        if (ic_we)
            check("ic_write", 128'({rdy_in, ic_wdata}),
                  128'({1'b1, ram_word(ic_addr)}));
    end

    task automatic step();
        @(posedge clk_in);
        #1;
    endtask

    task automatic sample();
        @(negedge clk_in);
    endtask

    task automatic do_flush(input logic [31:0] tgt);
        flush    = 1'b1;
        flush_pc = tgt;
        redir_q.push_back(tgt & ~32'd3);
        step();
        flush = 1'b0;
    endtask

    task automatic wait_fill_start(input string name);
        bit ok = 0;
        for (int i = 0; i < 40 && !ok; i++) begin
            sample();
            if (rdy_in && mem_req && mem_gnt) ok = 1;
            else step();
        end
        if (!ok) begin
            n_tests++;
            n_fail++;
            $display("FAIL %s: no granted fill within 40 cycles", name);
        end
    endtask

    task automatic wait_write(input string name);
        bit ok = 0;
        for (int i = 0; i < 40 && !ok; i++) begin
            step();
            sample();
            if (ic_we) ok = 1;
        end
        if (!ok) begin
            n_tests++;
            n_fail++;
            $display("FAIL %s: no cache write within 40 cycles", name);
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] q_pc, q_inst, q_addr;
        bit          seen;
        bit          ok;

        rst_in = 1'b1; rdy_in = 1'b1; flush = 1'b0; flush_pc = '0;
        inst_ready = 1'b1; gnt_now = 1'b1;
        ram_ovr[32'h100] = 8'h13;
        ram_ovr[32'h101] = 8'h05;
        ram_ovr[32'h102] = 8'h00;
        ram_ovr[32'h103] = 8'h00;
        for (int a = 0; a < 16; a++) begin
            cache[32'(a * 4)]          = ram_word(32'(a * 4));
            cache[32'h200 + 32'(a*4)]  = ram_word(32'h200 + 32'(a * 4));
        end

        // Reset values and first deliveries.
        repeat (3) step();
        sample();
        check("rst_flags", 128'({inst_valid, mem_req, ic_we}), 128'(3'b000));
        check("rst_inst", 128'({inst, inst_pc}), 128'(64'h0));
        check("rst_ic_addr", 128'(ic_addr), 128'(RESET_PC));
        step();
        rst_in = 1'b0;
        sample();
        check("t1_lat", 128'({inst_valid, ic_addr}), 128'({1'b0, RESET_PC}));
        for (int k = 0; k < 3; k++) begin
            step();
            sample();
            check("t1_seq", 128'({inst_valid, inst_pc}),
                  128'({1'b1, RESET_PC + 32'(4 * k)}));
        end

        // Miss with immediate grant and known bytes.
        step();
        do_flush(32'h100);
        wait_fill_start("t2_start");
        check("t2_addr", 128'(mem_addr), 128'(32'h100));
        for (int k = 1; k < 4; k++) begin
            step();
            sample();
            check("t2_addr", 128'(mem_addr), 128'(32'h100 + 32'(k)));
        end
        step(); sample();
        check("t2_req_fall", 128'(mem_req), 128'(1'b0));
        step(); sample();
        check("t2_write", 128'({ic_we, ic_wdata}), 128'({1'b1, 32'h0000_0513}));
        step(); sample();
        step(); sample();
        check("t2_valid", 128'({inst_valid, inst, inst_pc}),
              128'({1'b1, 32'h0000_0513, 32'h100}));

        // Backpressure: held outputs and frozen PC.
        step();
        do_flush(32'h10);
        ok = 0;
        for (int i = 0; i < 20 && !ok; i++) begin
            sample();
            if (inst_valid) ok = 1;
            else step();
        end
        check("t3_valid_seen", 128'(ok), 128'(1'b1));
        step();
        inst_ready = 1'b0;
        sample();
        q_pc = inst_pc; q_inst = inst; q_addr = ic_addr;
        check("t3_first_held", 128'(q_pc), 128'(32'h14));
        for (int i = 0; i < 4; i++) begin
            step(); sample();
            check("t3_hold", 128'({inst_valid, inst, inst_pc, ic_addr}),
                  128'({1'b1, q_inst, q_pc, q_addr}));
        end
        step();
        inst_ready = 1'b1;
        sample();
        step(); sample();
        check("t3_release", 128'({inst_valid, inst_pc}), 128'({1'b1, q_pc + 32'd4}));

        // Flush in the middle of a fill.
        step();
        do_flush(32'h300);
        wait_fill_start("t4_start");
        step();
        step();
        do_flush(32'h203);
        sample();
        check("t4_after_flush", 128'({mem_req, ic_we, ic_addr, inst_valid}),
              128'({1'b0, 1'b0, 32'h200, 1'b0}));
        seen = 0;
        for (int i = 0; i < 6; i++) begin
            step(); sample();
            seen |= ic_we;
        end
        check("t4_no_write", 128'(seen), 128'(1'b0));

        // rdy_in low in the middle of a fill.
        step();
        do_flush(32'h400);
        wait_fill_start("t5_start");
        step();
        step();
        rdy_in = 1'b0;
        for (int i = 0; i < 3; i++) begin
            if (i > 0) step();
            sample();
            check("t5_frozen", 128'({mem_addr, mem_req, ic_we}),
                  128'({32'h402, 1'b1, 1'b0}));
        end
        step();
        rdy_in = 1'b1;
        wait_write("t5_write");
        check("t5_word", 128'({ic_addr, ic_wdata}),
              128'({32'h400, ram_word(32'h400)}));

        // Delayed grant.
        step();
        gnt_now = 1'b0;
        do_flush(32'h500);
        ok = 0;
        for (int i = 0; i < 20 && !ok; i++) begin
            sample();
            if (mem_req) ok = 1;
            else step();
        end
        check("t6_req_seen", 128'(ok), 128'(1'b1));
        for (int i = 0; i < 4; i++) begin
            if (i > 0) begin step(); sample(); end
            check("t6_wait", 128'({mem_req, mem_gnt}), 128'(2'b10));
        end
        step();
        gnt_now = 1'b1;
        sample();
        check("t6_first", 128'({mem_gnt, mem_addr}), 128'({1'b1, 32'h500}));
        wait_write("t6_write");
        check("t6_word", 128'({ic_addr, ic_wdata}),
              128'({32'h500, ram_word(32'h500)}));

        // Randomized traffic.
        for (int a = 0; a < 512; a++)
            if ($urandom_range(1) == 0) cache[32'(a * 4)] = ram_word(32'(a * 4));
        for (int c = 0; c < 3000; c++) begin
            int unsigned r;
            step();
            rst_in     = 1'b0;
            flush      = 1'b0;
            rdy_in     = ($urandom_range(9) != 0);
            inst_ready = ($urandom_range(3) != 0);
            gnt_now    = ($urandom_range(2) == 0);
            r = $urandom_range(999);
            if (r < 2) begin
                rst_in = 1'b1;
                rdy_in = 1'b1;
            end else if (r < 30 && rdy_in) begin
                flush = 1'b1;
                if ($urandom_range(3) == 3)
                    flush_pc = 32'hFFFF_FFE0 | 32'($urandom_range(31));
                else
                    flush_pc = 32'($urandom_range(32'h7FF));
                redir_q.push_back(flush_pc & ~32'd3);
            end
        end
        step();
        rst_in = 1'b0; flush = 1'b0; rdy_in = 1'b1; inst_ready = 1'b1;
        repeat (20) step();
        sample();
        check("deliveries_enough", 128'(n_deliv >= 300), 128'(1'b1));
        check("redirects_drained", 128'(redir_q.size()), 128'(0));

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
